// File: rtl/read_byte_serializer_pkg.sv
// Shared state encoding and sizing helpers for the read byte serializer.
package read_byte_serializer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int bytes_per_word(input int word_w);
    return word_w / 8;
  endfunction

endpackage

// File: rtl/read_byte_serializer_word_fifo.sv
// Show-ahead word FIFO: head is the oldest stored word whenever empty is low.
module word_fifo
  import read_byte_serializer_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [WORD_W-1:0]         wdata,
  output logic [WORD_W-1:0]         head,
  output logic [clog2(DEPTH+1)-1:0] count,
  output logic                      empty,
  output logic                      full
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_C);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/read_byte_serializer.sv
// Prefetches memory words under a credit limit and serialises them into bytes.
module read_byte_serializer
  import read_byte_serializer_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      CLK_48MHZ,
  input  logic                      RESET,
  input  logic                      ENABLE,
  input  logic                      FLUSH,
  input  logic                      NEXT_BYTE,
  output logic                      READ_CMD,
  input  logic                      DATA_VALID,
  input  logic [WORD_W-1:0]         DATA_READ,
  output logic [7:0]                BYTE_OUT,
  output logic                      BYTE_VALID,
  output logic [clog2(DEPTH+1)-1:0] LEVEL,
  output logic                      UNDERRUN,
  output logic                      SPURIOUS
);
  localparam int BPW = bytes_per_word(WORD_W);
  localparam int CW  = clog2(DEPTH + 1);
  localparam int IW  = clog2(BPW);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

  logic [1:0]        state_q, state_d, run_state;
  logic [CW-1:0]     outst_q, outst_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              read_cmd_q, read_cmd_d;
  logic              underrun_q, underrun_d;
  logic              spurious_q, spurious_d;
  logic              dv_ok, push, pop;
  logic [CW-1:0]     level_next;
  logic [CW:0]       credits_next;
  logic [WORD_W-1:0] head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_full;
  logic [7:0]        lanes [BPW];

  word_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (CLK_48MHZ),
    .rst_n (RESET),
    .push  (push),
    .pop   (pop),
    .flush (FLUSH),
    .wdata (DATA_READ),
    .head  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Lane gi is the byte emitted when idx equals gi.
  for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
    assign lanes[gi] = MSB_FIRST ? head[WORD_W-1-8*gi -: 8] : head[8*gi +: 8];
  end

  always_comb begin
    dv_ok      = DATA_VALID && (outst_q != '0);
    push       = dv_ok && (state_q != ST_DISCARD) && !FLUSH && !fifo_full;
    pop        = 1'b0;
    idx_d      = idx_q;
    underrun_d = underrun_q;
    spurious_d = spurious_q || (DATA_VALID && (outst_q == '0));
    if (FLUSH) begin
      idx_d      = '0;
      underrun_d = 1'b0;
      spurious_d = 1'b0;
    end else if (NEXT_BYTE) begin
      if (!fifo_empty) begin
        if (idx_q == LAST_IDX) begin
          pop   = 1'b1;
          idx_d = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        underrun_d = 1'b1;
      end
    end
  end

  // Request decision uses next-cycle level and outstanding so credits never exceed DEPTH.
  always_comb begin
    run_state    = ENABLE ? ST_FETCH : ST_IDLE;
    outst_d      = outst_q + CW'(read_cmd_q) - CW'(dv_ok);
    level_next   = FLUSH ? '0 : (fifo_count + CW'(push) - CW'(pop));
    credits_next = {1'b0, level_next} + {1'b0, outst_d};
    state_d      = state_q;
    if (FLUSH) begin
      state_d = (outst_d != '0) ? ST_DISCARD : run_state;
    end else if (state_q == ST_DISCARD) begin
      if (outst_d == '0) state_d = run_state;
    end else begin
      state_d = run_state;
    end
    read_cmd_d = (state_d == ST_FETCH) && (credits_next < DEPTH_C) && !FLUSH;
  end

  always_ff @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      outst_q    <= '0;
      idx_q      <= '0;
      read_cmd_q <= 1'b0;
      underrun_q <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      outst_q    <= outst_d;
      idx_q      <= idx_d;
      read_cmd_q <= read_cmd_d;
      underrun_q <= underrun_d;
      spurious_q <= spurious_d;
    end
  end

  assign READ_CMD   = read_cmd_q;
  assign BYTE_VALID = !fifo_empty;
  assign BYTE_OUT   = fifo_empty ? 8'h00 : lanes[idx_q];
  assign LEVEL      = fifo_count;
  assign UNDERRUN   = underrun_q;
  assign SPURIOUS   = spurious_q;

endmodule

// File: doc/read_byte_serializer.md
# read_byte_serializer

Parametrised successor to the 16-bit read buffer. It prefetches words from the memory read path into a small FIFO and serialises them into bytes for a byte-wide consumer such as a UART or telemetry framer. Word width, FIFO depth and byte order are configurable. All logic is synchronous to the system clock with a proper request/valid handshake, and the block sits between the memory controller read port and the downlink framer.

## Interface
- WORD_W, 16, memory word width; multiple of 8, range 16..64; BPW = WORD_W/8
- DEPTH, 4, prefetch FIFO depth in words; power of 2, range 2..16
- MSB_FIRST, 1, 1 = byte [WORD_W-1 -: 8] sent first; 0 = byte [7:0] sent first
- CLK_48MHZ  in  1  system clock; single clock domain
- RESET  in  1  asynchronous, active-low reset
- ENABLE  in  1  1 = allow READ_CMD issue
- FLUSH  in  1  synchronous one-cycle clear of FIFO and byte index
- NEXT_BYTE  in  1  one-cycle strobe from consumer: current byte taken
- READ_CMD  out  1  one-cycle request for the next memory word
- DATA_VALID  in  1  one-cycle strobe: DATA_READ holds a requested word
- DATA_READ  in  WORD_W  returned memory word
- BYTE_OUT  out  8  current byte; 8'h00 when BYTE_VALID=0
- BYTE_VALID  out  1  BYTE_OUT is valid
- LEVEL  out  clog2(DEPTH+1)  words stored in FIFO
- UNDERRUN  out  1  sticky: NEXT_BYTE received while BYTE_VALID=0
- SPURIOUS  out  1  sticky: DATA_VALID received with no request outstanding

## Operation
- State machine with three states:
  - IDLE: ENABLE=0 and no flush pending.
  - FETCH: ENABLE=1; requests are issued.
  - DISCARD: flush is pending while requests are still outstanding.
- Credits: credits = LEVEL + outstanding. The outstanding counter is width clog2(DEPTH+1).
- READ_CMD is asserted in a cycle when all of these hold: state=FETCH, credits<DEPTH, FLUSH=0. It is a single cycle per request and issues at most one request per clock. outstanding increments on READ_CMD.
- On DATA_VALID with outstanding>0, outstanding decrements.
  - In FETCH or IDLE, the word is pushed.
  - In DISCARD, the word is dropped.
- On DATA_VALID with outstanding=0, nothing is pushed, SPURIOUS is set and nothing else changes.
- The FIFO cannot overflow because of the credit rule.
- The byte index runs 0..BPW-1 within the head word.
  - BYTE_OUT = head byte at position idx (MSB_FIRST=1) or position BPW-1-idx (MSB_FIRST=0), counted from the top byte.
- On NEXT_BYTE with BYTE_VALID=1: if idx=BPW-1, pop the head word and set idx to 0; otherwise idx+1.
- On NEXT_BYTE with BYTE_VALID=0: the strobe is ignored and UNDERRUN is set.
- Push and pop in the same cycle are legal; LEVEL is unchanged.
- FLUSH:
  - Empties the FIFO and sets idx to 0.
  - Clears UNDERRUN and SPURIOUS.
  - Goes to DISCARD if outstanding>0, otherwise to IDLE or FETCH according to ENABLE.
  - DISCARD exits when outstanding reaches 0.
  - A NEXT_BYTE in the same cycle as FLUSH is ignored and does not set UNDERRUN.
- Dropping ENABLE mid-stream stops new requests only. Outstanding words are still accepted and bytes still drain.

## Timing
- Reset values: READ_CMD=0, BYTE_VALID=0, BYTE_OUT=8'h00, LEVEL=0, UNDERRUN=0, SPURIOUS=0, idx=0, outstanding=0, state=IDLE.
- READ_CMD is registered. It asserts in the cycle after the condition becomes true, so the first request comes 1 cycle after ENABLE rises.
- Push latency: DATA_VALID at edge N gives BYTE_VALID=1 and LEVEL updated after edge N+1.
- NEXT_BYTE at edge N gives the new BYTE_OUT after edge N+1. A consumer may therefore strobe every cycle while BYTE_VALID=1.
- On an empty FIFO, DATA_VALID and NEXT_BYTE in the same cycle: the byte is not yet valid, so the strobe is an underrun and the word is still pushed.
- A pop that frees a credit produces READ_CMD on the following cycle.
- Reset asserted mid-transfer returns all state to reset values immediately. Words returning after reset are reported via SPURIOUS.

## Structure
- A shared package holds the state encoding (IDLE, FETCH, DISCARD), a clog2 function and the BPW derivation constant.
- One sub-module, word_fifo: a DEPTH x WORD_W synchronous FIFO with push, pop, flush, head, count, empty and full.
- The top level contains the credit/request FSM, the byte index and the byte mux.

## Test plan
- Reset, then ENABLE=1 with a memory model at 3-cycle latency, WORD_W=16, MSB_FIRST=1, words 16'hA1B2 and 16'hC3D4. Expected: bytes A1, B2, C3, D4 in order, and READ_CMD never leaves credits above 4.
- WORD_W=32, MSB_FIRST=0, word 32'h11223344. Expected: bytes 44, 33, 22, 11, and the pop occurs on the 4th NEXT_BYTE.
- Consumer stalled. Expected: exactly DEPTH READ_CMD pulses, LEVEL=DEPTH and no further requests. One full word consumed, then exactly one new READ_CMD appears 1 cycle after the pop.
- NEXT_BYTE while empty. Expected: UNDERRUN=1 and idx unchanged. Then FLUSH. Expected: UNDERRUN=0.
- FLUSH with 2 requests outstanding. Expected: state DISCARD, both returned words dropped, LEVEL stays 0, then FETCH resumes and the next word is delivered intact.
- DATA_VALID with nothing outstanding. Expected: SPURIOUS=1 and LEVEL unchanged. Also assert RESET mid-word. Expected: all outputs at reset values in the same cycle.
